riscv_decode_stage: RTL and testbench
=====================================

# riscv_decode_stage

Parametrised ID stage for the pipelined RV32I/RV32E core. Holds the IF/ID pipeline register with a valid/ready handshake, flush and load-use stall. Contains the architectural register file with optional write-back bypass. Presents the decoded register operands to EX, and counts stall cycles for performance monitoring.

## Interface
- XLEN, 32: datapath / PC width
- NREG, 32: architectural registers; 32 (RV32I) or 16 (RV32E)
- WB_BYPASS, 1: 1 = same-cycle write-back data forwarded to read ports; 0 = visible next cycle
- i_clk  in  1  clock; all state updates on rising edge
- i_rstn  in  1  reset; synchronous, active-low
- i_valid_f  in  1  fetch slot valid
- o_ready_f  out  1  ID accepts fetch slot this cycle
- i_instr_f  in  32  fetched instruction
- i_pc_f, i_pcplus4_f  in  XLEN  fetch PC, PC+4
- i_flush  in  1  branch/jump redirect from EX; kill ID contents
- o_valid_d  out  1  ID slot valid toward EX
- i_ready_e  in  1  EX accepts ID slot
- o_instr_d  out  32  registered instruction
- o_pc_d, o_pcplus4_d  out  XLEN  registered PC, PC+4
- o_rs1_addr_d, o_rs2_addr_d, o_rd_addr_d  out  5  instr[19:15], [24:20], [11:7]
- o_rs1_data_d, o_rs2_data_d  out  XLEN  register read data
- o_illegal_d  out  1  valid instruction names a register index >= NREG
- i_ex_valid, i_ex_is_load  in  1  EX holds a valid load
- i_ex_rd  in  5  EX destination register
- i_reg_wr_en_w  in  1  write-back enable
- i_rd_w  in  5  write-back destination
- i_result_w  in  XLEN  write-back data
- o_stall_cnt  out  32  load-use stall cycles, saturating

## Operation
- Pipeline register fields: valid, instr, pc, pcplus4.
- Reset values: valid=0; instr=32'h0000_0013 (NOP); pc=0; pcplus4=0; all registers=0; o_stall_cnt=0.
- Source usage from opcode instr[6:0]:
  - uses_rs1 = all opcodes except LUI 0110111, AUIPC 0010111, JAL 1101111.
  - uses_rs2 = R 0110011, S 0100011, B 1100011 only.
- hazard = valid & i_ex_valid & i_ex_is_load & i_ex_rd!=0 & ((uses_rs1 & i_ex_rd==rs1) | (uses_rs2 & i_ex_rd==rs2)).
- o_valid_d = valid & !hazard & !i_flush.
- o_ready_f = !valid | (i_ready_e & !hazard).
- Register update priority, highest first:
  - !i_rstn: reset.
  - i_flush: valid<=0; fetch slot dropped even if i_valid_f.
  - o_ready_f & i_valid_f: capture instr/pc/pcplus4; valid<=1.
  - o_ready_f & !i_valid_f: valid<=0.
  - Otherwise hold.
- Hazard: the instruction is held in ID, a bubble goes to EX (o_valid_d=0), fetch is back-pressured. The hazard clears once EX advances.
- Register file: NREG x XLEN.
  - x0 reads 0 and ignores writes.
  - Write on edge when i_reg_wr_en_w & i_rd_w!=0 & i_rd_w<NREG.
  - Reads are combinational from o_rs*_addr_d.
  - Out-of-range index (>=NREG) reads 0.
  - WB_BYPASS=1: a read address equal to an enabled, nonzero, in-range i_rd_w returns i_result_w in the same cycle.
- o_illegal_d = valid & (NREG==16) & ((uses_rs1 & rs1[4]) | (uses_rs2 & rs2[4]) | (rd_used & rd[4])). rd_used = all opcodes except S and B. Always 0 when NREG=32.
- o_stall_cnt increments by 1 on each cycle with hazard=1 and holds at 32'hFFFF_FFFF.

## Timing
- F->D latency: 1 cycle. A slot accepted at edge N is presented on o_*_d after edge N.
- Handshake:
  - Transfer to EX when o_valid_d & i_ready_e.
  - Once o_valid_d rises, o_instr_d/o_pc_d stay stable until transfer or flush.
  - Full-throughput back-to-back issue when i_ready_e=1 and there is no hazard.
- Back-pressure: i_ready_e=0 with valid=1 gives o_ready_f=0 and holds contents.
- Flush:
  - o_valid_d=0 in the flush cycle (combinational).
  - valid=0 after the edge.
  - Flush and hazard in the same cycle: flush wins, and the stall counter still increments for that cycle.
- Write-back in the same cycle as a read:
  - WB_BYPASS=1: new value seen in the same cycle.
  - WB_BYPASS=0: old value this cycle, new value from the next cycle.
- Reset asserted mid-operation: all state returns to reset values at the next edge regardless of other inputs.

## Test plan
- Stream ADDI x1..x4 with i_valid_f=1, i_ready_e=1 -> one o_valid_d per cycle, o_pc_d = 0,4,8,12 one cycle after each input, o_ready_f constantly 1.
- i_ready_e=0 for 3 cycles with ID full -> o_ready_f=0, o_instr_d/o_pc_d unchanged for 3 cycles, then resumes with no drop or duplicate.
- ID holds ADD x5,x6,x7; EX holds LW x7 (i_ex_valid=1, i_ex_is_load=1, i_ex_rd=7) -> o_valid_d=0, o_ready_f=0, o_stall_cnt 0->1; i_ex_valid drops -> ADD issues. With LUI x7 in ID, or i_ex_rd=0 -> no stall.
- Write x3=32'hDEAD_BEEF while ID reads rs1=x3 -> WB_BYPASS=1: o_rs1_data_d=DEADBEEF in the same cycle. WB_BYPASS=0: old value, then DEADBEEF next cycle. Write to x0 -> x0 still reads 0.
- i_flush=1 together with i_valid_f=1 and a valid ID slot -> o_valid_d=0 immediately, valid=0 next cycle, new slot not captured.
- NREG=16: ADD x17,x1,x2 valid -> o_illegal_d=1 and rs reads of x16+ return 0. Assert i_rstn=0 mid-stream -> next edge: o_valid_d=0, o_instr_d=32'h13, o_stall_cnt=0, all registers read 0.

Source files
------------

// File: rtl/riscv_decode_stage_if.sv
// Fetch/decode/execute/write-back signals seen by the ID stage.
// The slave modport is the decode stage; the master modport is its surroundings.
interface riscv_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            i_valid_f;
  logic            o_ready_f;
  logic [31:0]     i_instr_f;
  logic [XLEN-1:0] i_pc_f;
  logic [XLEN-1:0] i_pcplus4_f;
  logic            i_flush;
  logic            o_valid_d;
  logic            i_ready_e;
  logic [31:0]     o_instr_d;
  logic [XLEN-1:0] o_pc_d;
  logic [XLEN-1:0] o_pcplus4_d;
  logic [4:0]      o_rs1_addr_d;
  logic [4:0]      o_rs2_addr_d;
  logic [4:0]      o_rd_addr_d;
  logic [XLEN-1:0] o_rs1_data_d;
  logic [XLEN-1:0] o_rs2_data_d;
  logic            o_illegal_d;
  logic            i_ex_valid;
  logic            i_ex_is_load;
  logic [4:0]      i_ex_rd;
  logic            i_reg_wr_en_w;
  logic [4:0]      i_rd_w;
  logic [XLEN-1:0] i_result_w;
  logic [31:0]     o_stall_cnt;

  modport master (
    output i_valid_f, i_instr_f, i_pc_f, i_pcplus4_f, i_flush, i_ready_e,
           i_ex_valid, i_ex_is_load, i_ex_rd, i_reg_wr_en_w, i_rd_w, i_result_w,
    input  o_ready_f, o_valid_d, o_instr_d, o_pc_d, o_pcplus4_d,
           o_rs1_addr_d, o_rs2_addr_d, o_rd_addr_d, o_rs1_data_d, o_rs2_data_d,
           o_illegal_d, o_stall_cnt
  );

  modport slave (
    input  i_valid_f, i_instr_f, i_pc_f, i_pcplus4_f, i_flush, i_ready_e,
           i_ex_valid, i_ex_is_load, i_ex_rd, i_reg_wr_en_w, i_rd_w, i_result_w,
    output o_ready_f, o_valid_d, o_instr_d, o_pc_d, o_pcplus4_d,
           o_rs1_addr_d, o_rs2_addr_d, o_rd_addr_d, o_rs1_data_d, o_rs2_data_d,
           o_illegal_d, o_stall_cnt
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// RV32I/RV32E instruction decode stage: IF/ID register with handshake, flush and
// load-use stall, architectural register file with optional write-back bypass.
module riscv_decode_stage #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1
) (
  input logic                 i_clk,
  input logic                 i_rstn,
  riscv_decode_stage_if.slave bus
);
  localparam int          AW       = $clog2(NREG);
  localparam bit          IS_RV32E = (NREG == 16);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_S     = 7'b0100011;
  localparam logic [6:0]  OP_B     = 7'b1100011;

  function automatic logic inRange(input logic [4:0] idx);
    return int'(idx) < NREG;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic            slotValid_p0;
  logic [31:0]     slotInstr_p0;
  logic [XLEN-1:0] slotPc_p0;
  logic [XLEN-1:0] slotPc4_p0;
  logic [31:0]     stallCnt;
  logic [XLEN-1:0] regFile [NREG];

  logic [6:0]      opcode;
  logic [4:0]      rs1Addr, rs2Addr, rdAddr;
  logic            usesRs1, usesRs2, rdUsed;
  logic            hazard, readyF, wbWrite;
  logic [XLEN-1:0] rs1Data, rs2Data;

  assign opcode  = slotInstr_p0[6:0];
  assign rs1Addr = slotInstr_p0[19:15];
  assign rs2Addr = slotInstr_p0[24:20];
  assign rdAddr  = slotInstr_p0[11:7];

  assign usesRs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign usesRs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
  assign rdUsed  = !(opcode == OP_S || opcode == OP_B);

  // Load-use: the load's data is not available until after EX, so hold the consumer.
  assign hazard = slotValid_p0 && bus.i_ex_valid && bus.i_ex_is_load && (bus.i_ex_rd != 5'd0) &&
                  ((usesRs1 && bus.i_ex_rd == rs1Addr) || (usesRs2 && bus.i_ex_rd == rs2Addr));

  assign readyF  = !slotValid_p0 || (bus.i_ready_e && !hazard);
  assign wbWrite = bus.i_reg_wr_en_w && (bus.i_rd_w != 5'd0) && inRange(bus.i_rd_w);

  always_comb begin
    rs1Data = '0;
    if (rs1Addr != 5'd0 && inRange(rs1Addr)) begin
      rs1Data = regFile[rs1Addr[AW-1:0]];
      if (WB_BYPASS != 0 && wbWrite && bus.i_rd_w == rs1Addr) rs1Data = bus.i_result_w;
    end
  end

  always_comb begin
    rs2Data = '0;
    if (rs2Addr != 5'd0 && inRange(rs2Addr)) begin
      rs2Data = regFile[rs2Addr[AW-1:0]];
      if (WB_BYPASS != 0 && wbWrite && bus.i_rd_w == rs2Addr) rs2Data = bus.i_result_w;
    end
  end

  // IF -> ID pipeline register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      slotValid_p0 <= 1'b0;
      slotInstr_p0 <= NOP;
      slotPc_p0    <= '0;
      slotPc4_p0   <= '0;
    end else if (bus.i_flush) begin
      slotValid_p0 <= 1'b0;
    end else if (readyF) begin
      slotValid_p0 <= bus.i_valid_f;
      if (bus.i_valid_f) begin
        slotInstr_p0 <= bus.i_instr_f;
        slotPc_p0    <= bus.i_pc_f;
        slotPc4_p0   <= bus.i_pcplus4_f;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      stallCnt <= '0;
      for (int i = 0; i < NREG; i++) regFile[i] <= '0;
    end else begin
      if (hazard) stallCnt <= satInc(stallCnt);
      if (wbWrite) regFile[bus.i_rd_w[AW-1:0]] <= bus.i_result_w;
    end
  end

  assign bus.o_ready_f    = readyF;
  assign bus.o_valid_d    = slotValid_p0 && !hazard && !bus.i_flush;
  assign bus.o_instr_d    = slotInstr_p0;
  assign bus.o_pc_d       = slotPc_p0;
  assign bus.o_pcplus4_d  = slotPc4_p0;
  assign bus.o_rs1_addr_d = rs1Addr;
  assign bus.o_rs2_addr_d = rs2Addr;
  assign bus.o_rd_addr_d  = rdAddr;
  assign bus.o_rs1_data_d = rs1Data;
  assign bus.o_rs2_data_d = rs2Data;
  assign bus.o_illegal_d  = slotValid_p0 && IS_RV32E &&
                            ((usesRs1 && rs1Addr[4]) || (usesRs2 && rs2Addr[4]) || (rdUsed && rdAddr[4]));
  assign bus.o_stall_cnt  = stallCnt;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: three configurations (RV32I bypass, RV32I no bypass,
// RV32E bypass) share one stimulus stream and are compared against a reference model.
module tb_riscv_decode_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, validF, flush, readyE, exValid, exLoad, wrEn;
  logic [31:0] instrF, pcF, resW;
  logic [4:0]  exRd, rdW;

  logic        oValid[3], oReady[3], oIll[3];
  logic [4:0]  oA1[3], oA2[3], oAd[3];
  logic [31:0] oInstr[3], oPc[3], oPc4[3], oRs1[3], oRs2[3], oStall[3];

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int NR = (k == 2) ? 16 : 32;
    localparam int BP = (k == 1) ? 0 : 1;
    riscv_decode_stage_if #(.XLEN(32)) bus();
    assign bus.i_valid_f     = validF;
    assign bus.i_instr_f     = instrF;
    assign bus.i_pc_f        = pcF;
    assign bus.i_pcplus4_f   = pcF + 32'd4;
    assign bus.i_flush       = flush;
    assign bus.i_ready_e     = readyE;
    assign bus.i_ex_valid    = exValid;
    assign bus.i_ex_is_load  = exLoad;
    assign bus.i_ex_rd       = exRd;
    assign bus.i_reg_wr_en_w = wrEn;
    assign bus.i_rd_w        = rdW;
    assign bus.i_result_w    = resW;
    assign oValid[k] = bus.o_valid_d;
    assign oReady[k] = bus.o_ready_f;
    assign oIll[k]   = bus.o_illegal_d;
    assign oA1[k]    = bus.o_rs1_addr_d;
    assign oA2[k]    = bus.o_rs2_addr_d;
    assign oAd[k]    = bus.o_rd_addr_d;
    assign oInstr[k] = bus.o_instr_d;
    assign oPc[k]    = bus.o_pc_d;
    assign oPc4[k]   = bus.o_pcplus4_d;
    assign oRs1[k]   = bus.o_rs1_data_d;
    assign oRs2[k]   = bus.o_rs2_data_d;
    assign oStall[k] = bus.o_stall_cnt;
    riscv_decode_stage #(.XLEN(32), .NREG(NR), .WB_BYPASS(BP)) dut (
      .i_clk(clk), .i_rstn(rstn), .bus(bus)
    );
  end

  int passCnt = 0;
  int totalCnt = 0;

  task automatic checkVal(input string name, input int k, input logic [255:0] act, input logic [255:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic        mValid[3];
  logic [31:0] mInstr[3], mPc[3], mPc4[3], mStall[3];
  logic [31:0] mRegs[3][32];

  function automatic int nregOf(input int k); return (k == 2) ? 16 : 32; endfunction
  function automatic bit bypOf(input int k); return k != 1; endfunction

  function automatic logic usesRs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction
  function automatic logic usesRs2(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction
  function automatic logic rdUsed(input logic [6:0] op);
    return !(op == 7'b0100011 || op == 7'b1100011);
  endfunction

  function automatic logic mHazard(input int k);
    logic [31:0] ins = mInstr[k];
    return mValid[k] && exValid && exLoad && exRd != 0 &&
           ((usesRs1(ins[6:0]) && exRd == ins[19:15]) || (usesRs2(ins[6:0]) && exRd == ins[24:20]));
  endfunction

  function automatic logic [31:0] mRead(input int k, input logic [4:0] a);
    if (a == 0 || int'(a) >= nregOf(k)) return 32'd0;
    if (bypOf(k) && wrEn && rdW == a) return resW;
    return mRegs[k][a];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mValid[k] = 1'b0; mInstr[k] = 32'h13; mPc[k] = 0; mPc4[k] = 0; mStall[k] = 0;
      for (int r = 0; r < 32; r++) mRegs[k][r] = 0;
    end
  endtask

  task automatic checkModel();
    logic [255:0] act, exp;
    logic [31:0] ins;
    logic hz, eV, eR, eI;
    for (int k = 0; k < 3; k++) begin
      ins = mInstr[k];
      hz = mHazard(k);
      eV = mValid[k] && !hz && !flush;
      eR = !mValid[k] || (readyE && !hz);
      eI = mValid[k] && nregOf(k) == 16 &&
           ((usesRs1(ins[6:0]) && ins[19:15] >= 16) || (usesRs2(ins[6:0]) && ins[24:20] >= 16) ||
            (rdUsed(ins[6:0]) && ins[11:7] >= 16));
      act = 256'({oValid[k], oReady[k], oIll[k], oA1[k], oA2[k], oAd[k], oInstr[k], oPc[k], oPc4[k],
                  oRs1[k], oRs2[k], oStall[k]});
      exp = 256'({eV, eR, eI, ins[19:15], ins[24:20], ins[11:7], ins, mPc[k], mPc4[k],
                  mRead(k, ins[19:15]), mRead(k, ins[24:20]), mStall[k]});
      checkVal("model", k, act, exp);
    end
  endtask

  task automatic modelEdge();
    logic hz, eR;
    for (int k = 0; k < 3; k++) begin
      hz = mHazard(k);
      eR = !mValid[k] || (readyE && !hz);
      if (!rstn) begin
        mValid[k] = 1'b0; mInstr[k] = 32'h13; mPc[k] = 0; mPc4[k] = 0; mStall[k] = 0;
        for (int r = 0; r < 32; r++) mRegs[k][r] = 0;
      end else begin
        if (hz && mStall[k] != 32'hFFFF_FFFF) mStall[k] = mStall[k] + 1;
        if (wrEn && rdW != 0 && int'(rdW) < nregOf(k)) mRegs[k][rdW] = resW;
        if (flush) mValid[k] = 1'b0;
        else if (eR) begin
          mValid[k] = validF;
          if (validF) begin mInstr[k] = instrF; mPc[k] = pcF; mPc4[k] = pcF + 4; end
        end
      end
    end
  endtask

  task automatic settle(); #1; checkModel(); endtask
  task automatic advance(); @(posedge clk); modelEdge(); @(negedge clk); endtask

  task automatic idle();
    rstn = 1; validF = 0; instrF = 0; pcF = 0; flush = 0; readyE = 0;
    exValid = 0; exLoad = 0; exRd = 0; wrEn = 0; rdW = 0; resW = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rstn, validF; logic [31:0] instr, pc; logic flush, readyE, exV, exL; logic [4:0] exRd;
    logic wr; logic [4:0] rdW; logic [31:0] res;
    logic eV, eR; logic [31:0] eInstr, ePc, eRs1, eRs2, eSt;
  } vec_t;

  function automatic vec_t row(input logic rs, vF, input logic [31:0] ins, pc, input logic fl, rE, xV, xL,
                               input logic [4:0] xRd, input logic wr, input logic [4:0] rd, input logic [31:0] res,
                               input logic eV, eR, input logic [31:0] eIns, ePc, eR1, eR2, eSt);
    vec_t v;
    v.rstn = rs; v.validF = vF; v.instr = ins; v.pc = pc; v.flush = fl; v.readyE = rE;
    v.exV = xV; v.exL = xL; v.exRd = xRd; v.wr = wr; v.rdW = rd; v.res = res;
    v.eV = eV; v.eR = eR; v.eInstr = eIns; v.ePc = ePc; v.eRs1 = eR1; v.eRs2 = eR2; v.eSt = eSt;
    return v;
  endfunction

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] ADDI3 = 32'h0030_0193;
  localparam logic [31:0] ADDI4 = 32'h0040_0213;
  localparam logic [31:0] ADDR  = 32'h0073_02B3;  // add x5,x6,x7
  localparam logic [31:0] LUI7  = 32'h0003_83B7;  // lui x7 with rs1 field = 7
  localparam logic [31:0] ADDI8 = 32'h0001_8413;  // addi x8,x3,0
  localparam logic [31:0] DB    = 32'hDEAD_BEEF;

  vec_t tbl[$];

  initial begin
    tbl.push_back(row(1,1,ADDI1,0,  0,1,0,0,0, 0,0,0,            0,1,NOP,  0, 0,0,0));
    tbl.push_back(row(1,1,ADDI2,4,  0,1,0,0,0, 0,0,0,            1,1,ADDI1,0, 0,0,0));
    tbl.push_back(row(1,1,ADDI3,8,  0,1,0,0,0, 0,0,0,            1,1,ADDI2,4, 0,0,0));
    tbl.push_back(row(1,1,ADDI4,12, 0,1,0,0,0, 0,0,0,            1,1,ADDI3,8, 0,0,0));
    tbl.push_back(row(1,1,ADDR,16,  0,0,0,0,0, 0,0,0,            1,0,ADDI4,12,0,0,0));
    tbl.push_back(row(1,1,ADDR,16,  0,0,0,0,0, 0,0,0,            1,0,ADDI4,12,0,0,0));
    tbl.push_back(row(1,1,ADDR,16,  0,0,0,0,0, 0,0,0,            1,0,ADDI4,12,0,0,0));
    tbl.push_back(row(1,1,ADDR,16,  0,1,0,0,0, 0,0,0,            1,1,ADDI4,12,0,0,0));
    tbl.push_back(row(1,1,LUI7,20,  0,1,1,1,7, 0,0,0,            0,0,ADDR, 16,0,0,0));
    tbl.push_back(row(1,1,LUI7,20,  0,1,0,0,0, 0,0,0,            1,1,ADDR, 16,0,0,1));
    tbl.push_back(row(1,1,ADDR,24,  0,1,1,1,7, 0,0,0,            1,1,LUI7, 20,0,0,1));
    tbl.push_back(row(1,1,ADDI8,28, 0,1,1,1,0, 0,0,0,            1,1,ADDR, 24,0,0,1));
    tbl.push_back(row(1,0,0,0,      0,0,0,0,0, 1,3,DB,           1,0,ADDI8,28,DB,0,1));
    tbl.push_back(row(1,0,0,0,      0,0,0,0,0, 1,0,32'h12345678, 1,0,ADDI8,28,DB,0,1));
    tbl.push_back(row(1,1,ADDI1,40, 1,1,0,0,0, 0,0,0,            0,1,ADDI8,28,DB,0,1));
    tbl.push_back(row(1,0,0,0,      0,1,0,0,0, 0,0,0,            0,1,ADDI8,28,DB,0,1));
    tbl.push_back(row(1,1,ADDR,44,  0,1,0,0,0, 0,0,0,            0,1,ADDI8,28,DB,0,1));
    tbl.push_back(row(1,1,ADDI1,48, 1,1,1,1,7, 0,0,0,            0,0,ADDR, 44,0,0,1));
    tbl.push_back(row(1,0,0,0,      0,1,0,0,0, 0,0,0,            0,1,ADDR, 44,0,0,2));
    tbl.push_back(row(0,1,ADDR,52,  0,1,0,0,0, 0,0,0,            0,1,ADDR, 44,0,0,2));
    tbl.push_back(row(1,1,ADDI8,96, 0,1,0,0,0, 0,0,0,            0,1,NOP,  0, 0,0,0));
    tbl.push_back(row(1,0,0,0,      0,1,0,0,0, 0,0,0,            1,1,ADDI8,96,0,0,0));

    idle();
    rstn = 0;
    repeat (2) @(posedge clk);
    modelReset();
    @(negedge clk);

    foreach (tbl[i]) begin
      rstn = tbl[i].rstn; validF = tbl[i].validF; instrF = tbl[i].instr; pcF = tbl[i].pc;
      flush = tbl[i].flush; readyE = tbl[i].readyE; exValid = tbl[i].exV; exLoad = tbl[i].exL;
      exRd = tbl[i].exRd; wrEn = tbl[i].wr; rdW = tbl[i].rdW; resW = tbl[i].res;
      settle();
      checkVal($sformatf("row%0d", i), 0,
               256'({oValid[0], oReady[0], oInstr[0], oPc[0], oRs1[0], oRs2[0], oStall[0]}),
               256'({tbl[i].eV, tbl[i].eR, tbl[i].eInstr, tbl[i].ePc, tbl[i].eRs1, tbl[i].eRs2, tbl[i].eSt}));
      advance();
    end

    // RV32E: write x17 while fetching add x1,x17,x18, then inspect the slot
    idle();
    validF = 1; instrF = 32'h0128_80B3; pcF = 32'h100; readyE = 1;
    wrEn = 1; rdW = 5'd17; resW = 32'hCAFE_F00D;
    settle(); advance();
    idle();
    settle();
    checkVal("rv32e_illegal_rs", 2, 256'(oIll[2]), 256'(1'b1));
    checkVal("rv32e_rs1_x17",    2, 256'(oRs1[2]), 256'(32'd0));
    checkVal("rv32i_legal",      0, 256'(oIll[0]), 256'(1'b0));
    checkVal("rv32i_rs1_x17",    0, 256'(oRs1[0]), 256'(32'hCAFE_F00D));
    advance();
    validF = 1; instrF = 32'h0020_88B3; pcF = 32'h104; readyE = 1;
    settle(); advance();
    idle();
    settle();
    checkVal("rv32e_illegal_rd", 2, 256'(oIll[2]), 256'(1'b1));
    advance();

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] ops[9];
      logic [31:0] ins;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) < 7) begin
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end
      rstn    = ($urandom_range(0, 99) != 0);
      validF  = ($urandom_range(0, 3) != 0);
      instrF  = ins;
      pcF     = $urandom & 32'hFFFF_FFFC;
      flush   = ($urandom_range(0, 9) == 0);
      readyE  = ($urandom_range(0, 3) != 0);
      exValid = ($urandom_range(0, 1) != 0);
      exLoad  = ($urandom_range(0, 1) != 0);
      exRd    = 5'($urandom_range(0, 3));
      wrEn    = ($urandom_range(0, 1) != 0);
      rdW     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      resW    = $urandom;
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
